// File: rtl/axi4_lite_slave_mem_if.sv
// AXI4-Lite bus bundle between the CPU master and the data memory slave.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R). Clock and reset are
// kept as plain ports on the modules that use this interface.
//   slave  modport : AW/W/AR request + B/R ready are inputs, the rest outputs
//   master modport : mirror image of the slave modport
interface axi4_lite_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave data memory.
// Word-addressed synchronous RAM split into four byte lanes, each with its own
// write enable, so WSTRB maps directly onto lane enables. After reset the RAM
// is zero-filled one word per cycle; bus readies stay low until that finishes.
// Ports:
//   S_AXI_ACLK     clock
//   S_AXI_ARESETN  asynchronous active-low reset
//   s_axi          AXI4-Lite slave bus (AW, W, B, AR, R channels)
//   mem_init_done  high once the zero-fill sequence has completed

// One byte lane of the RAM plus its registered read port.
// Ports: i_we/i_widx/i_wdata write port; i_re/i_ridx read strobe and index,
// i_rzero forces the captured byte to 0; o_rdata holds the last read byte.
module axi4_lite_slave_mem_lane #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [7:0]       i_wdata,
    input  logic             i_re,
    input  logic             i_rzero,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [7:0]       o_rdata
);
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    // Array is deliberately not reset; the zero-fill sequence clears it.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_widx] <= i_wdata;
    end

    // Reads sample the array before this edge's write lands: read-first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_q <= '0;
        else if (i_re) r_q <= i_rzero ? 8'h00 : r_mem[i_ridx];
    end

    assign o_rdata = r_q;
endmodule

module axi4_lite_slave_mem #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH_WORDS    = 1024,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    axi4_lite_slave_mem_if.slave s_axi,
    output logic                 mem_init_done
);
    localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] C_SPAN = AW'(MEM_DEPTH_WORDS * 4);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    // ---------------------------------------------------------------- init
    // Counter MSB marks "all words written"; done follows one cycle later.
    logic [CNT_W-1:0] r_init_cnt;
    logic             r_init_done;
    logic             w_init_we;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            if (!r_init_cnt[IDX_W]) r_init_cnt <= r_init_cnt + CNT_W'(1);
            r_init_done <= r_init_cnt[IDX_W];
        end
    end

    // Gated by reset so a held reset never touches the array.
    assign w_init_we     = S_AXI_ARESETN && !r_init_cnt[IDX_W];
    assign mem_init_done = r_init_done;

    // ---------------------------------------------------------- write path
    logic [AW-1:0]    r_awaddr;
    logic [3:0][7:0]  r_wdata;
    logic [3:0]       r_wstrb;
    logic [1:0]       r_bresp;

    logic             w_awready, w_wready, w_commit;
    logic             w_aw_hs, w_w_hs;
    logic [AW-1:0]    w_cm_addr, w_cm_off;
    logic             w_cm_in;
    logic [IDX_W-1:0] w_cm_idx;
    logic [3:0][7:0]  w_cm_data;
    logic [3:0]       w_cm_strb;

    assign w_aw_hs = s_axi.S_AXI_AWVALID && w_awready;
    assign w_w_hs  = s_axi.S_AXI_WVALID  && w_wready;

    // Whichever half arrived first was latched; the other comes off the bus.
    assign w_cm_addr = (r_wstate == W_HAVE_ADDR) ? r_awaddr : s_axi.S_AXI_AWADDR;
    assign w_cm_data = (r_wstate == W_HAVE_DATA) ? r_wdata  : s_axi.S_AXI_WDATA;
    assign w_cm_strb = (r_wstate == W_HAVE_DATA) ? r_wstrb  : s_axi.S_AXI_WSTRB;
    assign w_cm_off  = w_cm_addr - BASE_ADDR;
    assign w_cm_in   = (w_cm_addr >= BASE_ADDR) && (w_cm_off < C_SPAN);
    assign w_cm_idx  = w_cm_off[IDX_W+1:2];

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = r_init_done;
                w_wready  = r_init_done;
                if (r_init_done && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end else if (r_init_done && s_axi.S_AXI_AWVALID) begin
                    w_wstate_nxt = W_HAVE_ADDR;
                end else if (r_init_done && s_axi.S_AXI_WVALID) begin
                    w_wstate_nxt = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                w_wready = 1'b1;
                if (s_axi.S_AXI_WVALID) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                w_awready = 1'b1;
                if (s_axi.S_AXI_AWVALID) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs) r_awaddr <= s_axi.S_AXI_AWADDR;
            if (w_w_hs) begin
                r_wdata <= s_axi.S_AXI_WDATA;
                r_wstrb <= s_axi.S_AXI_WSTRB;
            end
            if (w_commit) r_bresp <= w_cm_in ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi.S_AXI_AWREADY = w_awready;
    assign s_axi.S_AXI_WREADY  = w_wready;
    assign s_axi.S_AXI_BVALID  = (r_wstate == W_RESP);
    assign s_axi.S_AXI_BRESP   = r_bresp;

    // ----------------------------------------------------------- read path
    logic             w_arready, w_ar_hs, w_ar_in;
    logic [AW-1:0]    w_ar_off;
    logic [IDX_W-1:0] w_ar_idx;
    logic [1:0]       r_rresp;

    assign w_ar_off = s_axi.S_AXI_ARADDR - BASE_ADDR;
    assign w_ar_in  = (s_axi.S_AXI_ARADDR >= BASE_ADDR) && (w_ar_off < C_SPAN);
    assign w_ar_idx = w_ar_off[IDX_W+1:2];
    assign w_ar_hs  = s_axi.S_AXI_ARVALID && w_arready;

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = r_init_done;
                if (r_init_done && s_axi.S_AXI_ARVALID) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rstate <= R_IDLE;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) r_rresp <= w_ar_in ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi.S_AXI_ARREADY = w_arready;
    assign s_axi.S_AXI_RVALID  = (r_rstate == R_DATA);
    assign s_axi.S_AXI_RRESP   = r_rresp;

    // ------------------------------------------------------------ RAM lanes
    // Init and commit never overlap: readies are low while init runs.
    logic [3:0]       w_ram_we;
    logic [IDX_W-1:0] w_ram_widx;
    logic [3:0][7:0]  w_ram_wdata;
    logic [3:0][7:0]  w_rdata;

    assign w_ram_widx  = w_init_we ? r_init_cnt[IDX_W-1:0] : w_cm_idx;
    assign w_ram_wdata = w_init_we ? '0 : w_cm_data;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        assign w_ram_we[l] = w_init_we || (w_commit && w_cm_in && w_cm_strb[l]);

        axi4_lite_slave_mem_lane #(
            .DEPTH (MEM_DEPTH_WORDS),
            .IDX_W (IDX_W)
        ) u_lane (
            .i_clk   (S_AXI_ACLK),
            .i_rst_n (S_AXI_ARESETN),
            .i_we    (w_ram_we[l]),
            .i_widx  (w_ram_widx),
            .i_wdata (w_ram_wdata[l]),
            .i_re    (w_ar_hs),
            .i_rzero (!w_ar_in),
            .i_ridx  (w_ar_idx),
            .o_rdata (w_rdata[l])
        );
    end

    assign s_axi.S_AXI_RDATA = w_rdata;

    // Protection bits and sub-word offset bits carry no meaning here.
    logic w_unused;
    assign w_unused = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        w_cm_off[1:0], w_ar_off[1:0],
                        w_cm_off[AW-1:IDX_W+2], w_ar_off[AW-1:IDX_W+2]};
endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
module tb_axi4_lite_slave_mem;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk;
    logic rst_n;
    logic init_done;
    int   n_cmp;
    int   n_err;

    logic [31:0] ref_mem [DEPTH];

    axi4_lite_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_slave_mem #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .MEM_DEPTH_WORDS    (DEPTH),
        .BASE_ADDR          (BASE)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus.slave),
        .mem_init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: flat word array addressed by plain byte arithmetic.
    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < DEPTH * 4);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (!in_rng(a)) return 32'h0;
        return ref_mem[(a - BASE) >> 2];
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (!in_rng(a)) return;
        idx = int'((a - BASE) >> 2);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic idle_bus();
        bus.S_AXI_AWADDR  = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
    endtask

    // Called right after reset release; counts cycles until init completes.
    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 200) begin
            chk("init_awready", bus.S_AXI_AWREADY, 1'b0);
            chk("init_wready",  bus.S_AXI_WREADY,  1'b0);
            chk("init_arready", bus.S_AXI_ARREADY, 1'b0);
            tick();
            n++;
        end
        chk("init_cycles", n, DEPTH + 1);
        chk("init_done", init_done, 1'b1);
        chk("rdy_aw_after_init", bus.S_AXI_AWREADY, 1'b1);
        chk("rdy_ar_after_init", bus.S_AXI_ARREADY, 1'b1);
    endtask

    // AW pulsed at cycle aw_d, W at w_d (relative); BREADY after b_d cycles.
    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_d, input int w_d, input int b_d);
        int          last;
        logic [1:0]  eresp;
        last  = (aw_d > w_d) ? aw_d : w_d;
        eresp = in_rng(a) ? 2'b00 : 2'b10;
        for (int t = 0; t <= last; t++) begin
            bus.S_AXI_AWVALID = (t == aw_d);
            bus.S_AXI_AWADDR  = (t == aw_d) ? a : $urandom;
            bus.S_AXI_WVALID  = (t == w_d);
            bus.S_AXI_WDATA   = (t == w_d) ? d : $urandom;
            bus.S_AXI_WSTRB   = (t == w_d) ? s : 4'($urandom);
            chk("wr_awready", bus.S_AXI_AWREADY, (t <= aw_d));
            chk("wr_wready",  bus.S_AXI_WREADY,  (t <= w_d));
            chk("wr_bvalid_early", bus.S_AXI_BVALID, 1'b0);
            tick();
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_AWADDR  = $urandom;
        bus.S_AXI_WDATA   = $urandom;
        for (int k = 0; k <= b_d; k++) begin
            chk("wr_bvalid", bus.S_AXI_BVALID, 1'b1);
            chk("wr_bresp",  bus.S_AXI_BRESP, eresp);
            chk("wr_awready_resp", bus.S_AXI_AWREADY, 1'b0);
            chk("wr_wready_resp",  bus.S_AXI_WREADY,  1'b0);
            bus.S_AXI_BREADY = (k == b_d);
            tick();
        end
        bus.S_AXI_BREADY = 1'b0;
        chk("wr_bvalid_clr", bus.S_AXI_BVALID, 1'b0);
        chk("wr_awready_back", bus.S_AXI_AWREADY, 1'b1);
        chk("wr_wready_back",  bus.S_AXI_WREADY,  1'b1);
        model_wr(a, d, s);
    endtask

    task automatic axi_rd(input logic [31:0] a, input int r_d);
        logic [31:0] ed;
        logic [1:0]  er;
        ed = exp_rd(a);
        er = in_rng(a) ? 2'b00 : 2'b10;
        chk("rd_arready", bus.S_AXI_ARREADY, 1'b1);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_ARADDR  = $urandom;
        for (int k = 0; k <= r_d; k++) begin
            chk("rd_rvalid", bus.S_AXI_RVALID, 1'b1);
            chk("rd_rdata",  bus.S_AXI_RDATA, ed);
            chk("rd_rresp",  bus.S_AXI_RRESP, er);
            chk("rd_arready_busy", bus.S_AXI_ARREADY, 1'b0);
            bus.S_AXI_RREADY = (k == r_d);
            tick();
        end
        bus.S_AXI_RREADY = 1'b0;
        chk("rd_rvalid_clr", bus.S_AXI_RVALID, 1'b0);
        chk("rd_arready_back", bus.S_AXI_ARREADY, 1'b1);
    endtask

    initial begin
        logic [31:0] a, d, old;
        n_cmp = 0;
        n_err = 0;
        idle_bus();
        model_clear();

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_awready", bus.S_AXI_AWREADY, 1'b0);
        chk("rst_wready",  bus.S_AXI_WREADY,  1'b0);
        chk("rst_arready", bus.S_AXI_ARREADY, 1'b0);
        chk("rst_bvalid",  bus.S_AXI_BVALID,  1'b0);
        chk("rst_bresp",   bus.S_AXI_BRESP,   2'b00);
        chk("rst_rvalid",  bus.S_AXI_RVALID,  1'b0);
        chk("rst_rdata",   bus.S_AXI_RDATA,   32'h0);
        chk("rst_rresp",   bus.S_AXI_RRESP,   2'b00);
        chk("rst_init",    init_done,         1'b0);
        rst_n = 1'b1;
        wait_init();
        axi_rd(32'h14, 0);

        // Directed cases
        axi_wr(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        axi_rd(32'h10, 0);
        axi_wr(32'h20, 32'h1122_3344, 4'hF, 0, 0, 0);
        axi_wr(32'h20, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
        axi_rd(32'h20, 1);
        chk("strobe_merge", exp_rd(32'h20), 32'h11BB_33DD);
        axi_wr(32'h24, 32'h0000_0055, 4'hF, 0, 3, 0);
        axi_rd(32'h24, 0);
        axi_wr(32'h28, 32'h0BAD_F00D, 4'hF, 3, 0, 2);
        axi_rd(32'h2B, 0);
        axi_wr(BASE + DEPTH * 4, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
        axi_rd(BASE + DEPTH * 4, 0);
        axi_wr(32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 1, 0, 0);
        axi_rd(32'hFFFF_FFFC, 2);
        axi_rd(BASE + DEPTH * 4 - 4, 0);

        // Same-cycle read and write to one word: read returns old data
        old = exp_rd(32'h30);
        d   = 32'hC0FF_EE00 ^ old;
        bus.S_AXI_AWADDR = 32'h30; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA  = d;      bus.S_AXI_WSTRB   = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 32'h30; bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        chk("rf_rvalid", bus.S_AXI_RVALID, 1'b1);
        chk("rf_rdata",  bus.S_AXI_RDATA,  old);
        chk("rf_bvalid", bus.S_AXI_BVALID, 1'b1);
        chk("rf_bresp",  bus.S_AXI_BRESP,  2'b00);
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        chk("rf_bvalid_clr", bus.S_AXI_BVALID, 1'b0);
        chk("rf_rvalid_clr", bus.S_AXI_RVALID, 1'b0);
        model_wr(32'h30, d, 4'hF);
        axi_rd(32'h30, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            a = 32'($urandom_range(0, DEPTH + 3)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            if ($urandom_range(0, 1) == 1)
                axi_wr(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_rd(a, $urandom_range(0, 2));
        end
        for (int i = 0; i < DEPTH; i++) axi_rd(BASE + 32'(i * 4), 0);

        // B held off, then reset mid-wait
        bus.S_AXI_AWADDR = 32'h08; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA  = 32'h7777_8888; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_bvalid",  bus.S_AXI_BVALID,  1'b1);
            chk("hold_bresp",   bus.S_AXI_BRESP,   2'b00);
            chk("hold_awready", bus.S_AXI_AWREADY, 1'b0);
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_bvalid",  bus.S_AXI_BVALID,  1'b0);
        chk("arst_awready", bus.S_AXI_AWREADY, 1'b0);
        chk("arst_init",    init_done,         1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        model_clear();
        wait_init();
        axi_rd(32'h08, 0);
        axi_rd(32'h10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi4_lite_slave_mem.md
Name: axi4_lite_slave_mem

Overview:
AXI4-Lite slave data memory that sits directly downstream of the CPU's AXI4-Lite master and serves its read and write transactions. Internal word-addressed synchronous RAM with byte strobes, address-range checking and SLVERR responses. After reset it runs a zero-fill sequence and reports readiness on mem_init_done, which feeds the master's memory-busy/initialized inputs.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width (fixed at 32; WSTRB is 4 bits)
C_S_AXI_ADDR_WIDTH, 32, address bus width
MEM_DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte-lane enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response (00 OKAY, 10 SLVERR)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  master accepts response
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  master accepts read data
mem_init_done  out  1  high once zero-fill completes

Behaviour:
- Reset (ARESETN=0, asynchronous): all outputs 0; write FSM to W_IDLE, read FSM to R_IDLE, init counter to 0; RAM contents are not cleared by reset itself.
- Init: after reset release, one RAM word is written with 0 per cycle, addresses 0..MEM_DEPTH_WORDS-1. mem_init_done rises the cycle after the last word is written (MEM_DEPTH_WORDS+1 cycles after release). While init runs, AWREADY/WREADY/ARREADY stay 0.
- Ready-before-valid: the master pulses AWVALID/WVALID/ARVALID for a single cycle. When idle and initialized, AWREADY, WREADY and ARREADY are therefore held high so that any one-cycle valid is captured.
- Address decode: offset = addr - BASE_ADDR; word index = offset[...:2]; bits[1:0] ignored. The address is in range iff addr >= BASE_ADDR and offset < MEM_DEPTH_WORDS*4.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: AW and W handshaking in the same cycle -> commit, then W_RESP. AW only -> latch address, then W_HAVE_ADDR (AWREADY=0, WREADY=1). W only -> latch data and strobe, then W_HAVE_DATA (WREADY=0, AWREADY=1).
  - W_HAVE_ADDR / W_HAVE_DATA: on the missing handshake -> commit, then W_RESP.
  - Commit: RAM write on the handshake edge, only for lanes with WSTRB=1, and only if the address is in range.
  - W_RESP: BVALID=1 from the cycle after commit; BRESP=00 if in range, 10 if out of range (no RAM change). AWREADY=WREADY=0. BVALID and BRESP are held stable until BREADY=1. After the B handshake -> W_IDLE with readies high the next cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake the RAM is read synchronously; RVALID=1 the next cycle (1-cycle latency), ARREADY=0.
  - Out-of-range read: RDATA=0, RRESP=10. Otherwise RRESP=00.
  - R_DATA: RDATA/RRESP are held until RREADY=1, then R_IDLE.
- Simultaneous events: the read and write channels are independent and may handshake in the same cycle. If a read and a write commit target the same word in the same cycle, the read returns the old data (read-first).
- BVALID/RVALID never depend combinationally on BREADY/RREADY.
- Reset mid-transaction: outstanding responses are dropped, VALIDs go to 0 immediately, and init re-runs (RAM is re-zeroed).

Test Plan:
- Reset release, MEM_DEPTH_WORDS=16 -> mem_init_done rises 17 cycles after ARESETN goes high; readies stay 0 before that; a read of word 5 then returns 0, RRESP=00.
- Single-cycle AW+W to 0x10, data 0xDEADBEEF, WSTRB=1111, BREADY=1 -> BVALID=1 the next cycle, BRESP=00; read of 0x10 -> RVALID one cycle after AR, RDATA=0xDEADBEEF.
- Write 0x11223344 to 0x20, then 0xAABBCCDD with WSTRB=0101 -> a read returns 0x11BB33DD.
- AW to 0x24 in cycle N, W 0x55 in cycle N+3 -> AWREADY=0 during N+1..N+3, commit at N+3, BVALID at N+4; a read returns 0x55.
- Write to BASE_ADDR + MEM_DEPTH_WORDS*4 -> BRESP=10, RAM unchanged; read of the same address -> RDATA=0, RRESP=10.
- Hold BREADY=0 for 5 cycles after a write -> BVALID/BRESP stable throughout, AWREADY=0; assert ARESETN=0 mid-wait -> BVALID=0 asynchronously, init repeats.
